// File: rtl/costas_sign_slicer_pkg.sv
// Shared constants and sample type for the Costas loop hard-decision slicer.
package costas_pkg;

    localparam int COSTAS_DATA_W  = 14;
    localparam int COSTAS_MID_DEF = 5000;

    typedef logic [COSTAS_DATA_W-1:0] costas_sample_t;

endpackage : costas_pkg

// File: rtl/costas_sign_slicer_if.sv
// Sample-in / decision-out stream bundle of the sign slicer (no backpressure).
interface costas_sign_slicer_if
    import costas_pkg::*;
#(
    parameter int DATA_W = COSTAS_DATA_W,
    parameter int N_CH   = 2
) ();

    logic                     in_valid;
    logic [N_CH*DATA_W-1:0]   in_data;
    logic                     out_valid;
    logic [N_CH-1:0]          out_bits;
    logic [N_CH-1:0]          out_toggle;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_bits, out_toggle
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_bits, out_toggle
    );

endinterface : costas_sign_slicer_if

// File: rtl/costas_sign_slicer_hold_timer.sv
// Inversion window timer: flip_req (re)loads HOLD_LEN, then counts down to 0.
module sign_hold_timer #(
    parameter int HOLD_LEN = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic flip_req,
    output logic active
);

    // A zero-length window still needs a 1-bit counter; it simply never leaves 0.
    localparam int CNT_W = (HOLD_LEN == 0) ? 1 : $clog2(HOLD_LEN + 1);

    logic [CNT_W-1:0] hold_cnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (flip_req) begin
            hold_cnt <= CNT_W'(HOLD_LEN);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Derived from the register only, so reset closes the window asynchronously.
    assign active = (hold_cnt != '0);

endmodule : sign_hold_timer

// File: rtl/costas_sign_slicer.sv
// Multi-channel offset-binary hard-decision slicer with runtime midpoint,
// optional hysteresis deadband and a timed decision-inversion window.
module costas_sign_slicer
    import costas_pkg::*;
#(
    parameter int DATA_W   = COSTAS_DATA_W,
    parameter int N_CH     = 2,
    parameter int HOLD_LEN = 12,
    parameter int HYST     = 0,
    parameter int MID_RST  = COSTAS_MID_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_mid_we,
    input  logic [DATA_W-1:0]   cfg_mid,
    input  logic                flip_req,
    costas_sign_slicer_if.slave bus,
    output logic                invert_active
);

    localparam logic [DATA_W:0]   HYST_X = (DATA_W + 1)'(HYST);
    localparam logic [DATA_W:0]   LIMIT  = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] MID_R  = DATA_W'(MID_RST);

    logic [DATA_W-1:0] mid;
    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [N_CH-1:0]   raw_vec;
    logic [N_CH-1:0]   dec_vec;

    sign_hold_timer #(
        .HOLD_LEN (HOLD_LEN)
    ) u_hold_timer (
        .clk      (clk),
        .rst      (rst),
        .flip_req (flip_req),
        .active   (invert_active)
    );

    // Deadband edges in DATA_W+1 bits, clamped to the sample range.
    assign hi_sum = {1'b0, mid} + HYST_X;
    assign hi     = (hi_sum > LIMIT) ? LIMIT[DATA_W-1:0] : hi_sum[DATA_W-1:0];
    assign lo     = ({1'b0, mid} < HYST_X) ? '0 : (mid - HYST_X[DATA_W-1:0]);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_W-1:0] x;
        logic              raw;
        logic              dec;

        assign x = bus.in_data[c*DATA_W +: DATA_W];

        // NOTE: every path assigns raw, so this stays combinational (no latch).
        always_comb begin
            raw = dec;
            if (x >= hi) begin
                raw = 1'b1;
            end else if (x < lo) begin
                raw = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dec <= 1'b0;
            end else if (bus.in_valid) begin
                dec <= raw;
            end
        end

        assign raw_vec[c] = raw;
        assign dec_vec[c] = dec;
    end

    // Samples see the pre-edge midpoint and inversion state; updates land next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mid            <= MID_R;
            bus.out_valid  <= 1'b0;
            bus.out_bits   <= '0;
            bus.out_toggle <= '0;
        end else begin
            if (cfg_mid_we) begin
                mid <= cfg_mid;
            end
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.out_bits   <= raw_vec ^ {N_CH{invert_active}};
                bus.out_toggle <= raw_vec ^ dec_vec;
            end
        end
    end

endmodule : costas_sign_slicer

// File: tb/tb_costas_sign_slicer.sv
// Scoreboard bench: three slicer builds (plain, hysteresis, no-inversion) share one stimulus stream.
module tb_costas_sign_slicer;
    import costas_pkg::*;

    localparam int NCH  = 4;
    localparam int NDUT = 3;
    localparam int DW   = COSTAS_DATA_W;
    localparam int MAXV = (1 << DW) - 1;

    typedef struct {
        logic [NCH-1:0] bits;
        logic [NCH-1:0] tog;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_mid_we;
    costas_sample_t      cfg_mid;
    logic                flip_req;
    logic                in_valid;
    logic [NCH*DW-1:0]   in_data;

    logic [NDUT-1:0]     obs_valid;
    logic [NDUT-1:0]     obs_inv;
    logic [NCH-1:0]      obs_bits [NDUT];
    logic [NCH-1:0]      obs_tog  [NDUT];

    int hyst_t [NDUT] = '{0, 100, 0};
    int hold_t [NDUT] = '{12, 12, 0};

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc;
    int   last_flip;
    int   mid_m;
    bit   dec_m     [NDUT][NCH];
    logic [NCH-1:0] last_bits [NDUT];
    logic [NCH-1:0] last_tog  [NDUT];
    exp_t sbq [NDUT][$];

    costas_sign_slicer_if #(.DATA_W(DW), .N_CH(NCH)) if0 ();
    costas_sign_slicer_if #(.DATA_W(DW), .N_CH(NCH)) if1 ();
    costas_sign_slicer_if #(.DATA_W(DW), .N_CH(NCH)) if2 ();

    assign if0.in_valid = in_valid;
    assign if0.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.in_data  = in_data;
    assign if2.in_valid = in_valid;
    assign if2.in_data  = in_data;

    assign obs_valid = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign obs_bits[0] = if0.out_bits;
    assign obs_bits[1] = if1.out_bits;
    assign obs_bits[2] = if2.out_bits;
    assign obs_tog[0]  = if0.out_toggle;
    assign obs_tog[1]  = if1.out_toggle;
    assign obs_tog[2]  = if2.out_toggle;

    costas_sign_slicer #(.DATA_W(DW), .N_CH(NCH), .HOLD_LEN(12), .HYST(0), .MID_RST(5000)) dut0 (
        .clk(clk), .rst(rst), .cfg_mid_we(cfg_mid_we), .cfg_mid(cfg_mid),
        .flip_req(flip_req), .bus(if0), .invert_active(obs_inv[0]));

    costas_sign_slicer #(.DATA_W(DW), .N_CH(NCH), .HOLD_LEN(12), .HYST(100), .MID_RST(5000)) dut1 (
        .clk(clk), .rst(rst), .cfg_mid_we(cfg_mid_we), .cfg_mid(cfg_mid),
        .flip_req(flip_req), .bus(if1), .invert_active(obs_inv[1]));

    costas_sign_slicer #(.DATA_W(DW), .N_CH(NCH), .HOLD_LEN(0), .HYST(0), .MID_RST(5000)) dut2 (
        .clk(clk), .rst(rst), .cfg_mid_we(cfg_mid_we), .cfg_mid(cfg_mid),
        .flip_req(flip_req), .bus(if2), .invert_active(obs_inv[2]));

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decision rule: threshold with clamped deadband, memory inside it.
    function automatic bit model_raw(input int x, input int m, input int h, input bit prev);
        int hi_v;
        int lo_v;
        hi_v = (m + h > MAXV) ? MAXV : m + h;
        lo_v = (m - h < 0) ? 0 : m - h;
        if (x >= hi_v) return 1'b1;
        if (x < lo_v)  return 1'b0;
        return prev;
    endfunction

    function automatic logic [NCH*DW-1:0] rep(input int x);
        costas_sample_t s;
        s = costas_sample_t'(x);
        return {NCH{s}};
    endfunction

    function automatic int clampv(input int x);
        if (x < 0) return 0;
        if (x > MAXV) return MAXV;
        return x;
    endfunction

    function automatic logic [NCH*DW-1:0] rnd_data(input int m, input int span);
        logic [NCH*DW-1:0] d;
        d = '0;
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 3) == 0)
                d[c*DW +: DW] = costas_sample_t'($urandom_range(0, MAXV));
            else
                d[c*DW +: DW] = costas_sample_t'(clampv(m - span + int'($urandom_range(0, 2*span))));
        end
        return d;
    endfunction

    task automatic model_reset();
        mid_m     = 5000;
        last_flip = -1000;
        for (int d = 0; d < NDUT; d++) begin
            for (int c = 0; c < NCH; c++) dec_m[d][c] = 1'b0;
            last_bits[d] = '0;
            last_tog[d]  = '0;
            sbq[d].delete();
        end
    endtask

    // One clock of stimulus; expectations use the state in force before this edge.
    task automatic do_cycle(input bit v, input logic [NCH*DW-1:0] data,
                            input bit flip, input bit we, input int newmid);
        exp_t e;
        bit   inv;
        bit   raw;
        int   x;
        @(negedge clk);
        in_valid   = v;
        in_data    = data;
        flip_req   = flip;
        cfg_mid_we = we;
        cfg_mid    = costas_sample_t'(newmid);
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            inv    = (hold_t[d] > 0) && (cyc - last_flip <= hold_t[d]);
            e.bits = '0;
            e.tog  = '0;
            if (v) begin
                for (int c = 0; c < NCH; c++) begin
                    x         = int'(data[c*DW +: DW]);
                    raw       = model_raw(x, mid_m, hyst_t[d], dec_m[d][c]);
                    e.bits[c] = raw ^ inv;
                    e.tog[c]  = raw ^ dec_m[d][c];
                    dec_m[d][c] = raw;
                end
                sbq[d].push_back(e);
            end
        end
        if (flip) last_flip = cyc;
        if (we)   mid_m     = newmid;
        @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("invert_active d%0d c%0d", d, cyc), 32'(obs_inv[d]),
                  32'((hold_t[d] > 0) && (cyc + 1 - last_flip <= hold_t[d])));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst        = 1'b0;
        in_valid   = 1'b0;
        flip_req   = 1'b0;
        cfg_mid_we = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst out_valid d%0d", d), 32'(obs_valid[d]), 32'd0);
            check($sformatf("rst out_bits d%0d", d), 32'(obs_bits[d]), 32'd0);
            check($sformatf("rst out_toggle d%0d", d), 32'(obs_tog[d]), 32'd0);
            check($sformatf("rst invert_active d%0d", d), 32'(obs_inv[d]), 32'd0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: pop one expectation per out_valid; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int d = 0; d < NDUT; d++) begin
                if (obs_valid[d]) begin
                    if (sbq[d].size() == 0) begin
                        check($sformatf("unexpected out_valid d%0d", d), 32'(obs_valid[d]), 32'd0);
                    end else begin
                        exp_t e;
                        e = sbq[d].pop_front();
                        check($sformatf("out_bits d%0d", d), 32'(obs_bits[d]), 32'(e.bits));
                        check($sformatf("out_toggle d%0d", d), 32'(obs_tog[d]), 32'(e.tog));
                        last_bits[d] = e.bits;
                        last_tog[d]  = e.tog;
                    end
                end else begin
                    check($sformatf("hold out_bits d%0d", d), 32'(obs_bits[d]), 32'(last_bits[d]));
                    check($sformatf("hold out_toggle d%0d", d), 32'(obs_tog[d]), 32'(last_tog[d]));
                end
            end
        end
    end

    initial begin
        bit v;
        bit fl;
        bit we;
        int nm;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flip_req   = 1'b0;
        cfg_mid_we = 1'b0;
        cfg_mid    = '0;
        cyc        = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("init out_valid d%0d", d), 32'(obs_valid[d]), 32'd0);
            check($sformatf("init invert_active d%0d", d), 32'(obs_inv[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Threshold edge, then reset in the middle of an open window.
        do_cycle(1, rep(5000), 0, 0, 0);
        do_cycle(1, rep(4999), 0, 0, 0);
        do_cycle(1, rep(6000), 1, 0, 0);
        do_cycle(1, rep(6000), 0, 0, 0);
        do_reset();
        do_cycle(1, rep(5000), 0, 0, 0);
        do_cycle(1, rep(4999), 0, 0, 0);

        // Single window of HOLD_LEN samples.
        do_cycle(1, rep(6000), 1, 0, 0);
        repeat (13) do_cycle(1, rep(6000), 0, 0, 0);

        // Retrigger at t0+8 extends the window.
        do_cycle(1, rep(6000), 1, 0, 0);
        repeat (7) do_cycle(1, rep(6000), 0, 0, 0);
        do_cycle(1, rep(6000), 1, 0, 0);
        repeat (14) do_cycle(1, rep(6000), 0, 0, 0);

        // Hysteresis sequence around mid 5000.
        do_cycle(1, rep(4800), 0, 0, 0);
        do_cycle(1, rep(4950), 0, 0, 0);
        do_cycle(1, rep(5050), 0, 0, 0);
        do_cycle(1, rep(5100), 0, 0, 0);
        do_cycle(1, rep(5000), 0, 0, 0);
        do_cycle(1, rep(4899), 0, 0, 0);

        // Midpoint write coinciding with a sample.
        do_cycle(1, rep(6000), 0, 1, 8000);
        do_cycle(1, rep(6000), 0, 0, 0);
        do_cycle(0, rep(0), 0, 1, 5000);

        // Random traffic with gaps, flips and midpoint changes.
        for (int i = 0; i < 1000; i++) begin
            v  = ($urandom_range(0, 99) < 60);
            fl = ($urandom_range(0, 99) < 4);
            we = ($urandom_range(0, 99) < 3);
            case ($urandom_range(0, 3))
                0:       nm = 0;
                1:       nm = MAXV;
                2:       nm = 5000;
                default: nm = int'($urandom_range(0, MAXV));
            endcase
            do_cycle(v, rnd_data(mid_m, 150), fl, we, nm);
        end

        // Saturated deadband edges at both ends of the range.
        do_cycle(0, rep(0), 0, 1, MAXV);
        for (int i = 0; i < 200; i++)
            do_cycle($urandom_range(0, 3) != 0, rnd_data(MAXV - 150, 150),
                     $urandom_range(0, 49) == 0, 0, 0);
        do_cycle(0, rep(0), 0, 1, 0);
        for (int i = 0; i < 200; i++)
            do_cycle($urandom_range(0, 3) != 0, rnd_data(150, 150),
                     $urandom_range(0, 49) == 0, 0, 0);

        repeat (3) do_cycle(0, rep(0), 0, 0, 0);
        @(negedge clk);
        #1;
        for (int d = 0; d < NDUT; d++)
            check($sformatf("scoreboard drained d%0d", d), 32'(sbq[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_costas_sign_slicer
